// File: rtl/xform_streamer_pkg.sv
// Shared encodings and default widths for the xform_streamer descriptor walker.
package xform_streamer_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_LEN_W  = 10;
    localparam int unsigned DEF_CHAR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_FWD  = 2'd0,
        MODE_REV  = 2'd1,
        MODE_LOOP = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

endpackage

// File: rtl/xform_lat_pipe.sv
// Valid shift register matching the memory read latency; its output marks the capture cycle.
module xform_lat_pipe #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic out_valid
);

    logic [LAT-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sr <= '0;
        end else begin
            sr[0] <= in_valid;
            for (int unsigned i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign out_valid = sr[LAT-1];

endmodule

// File: rtl/xform_streamer.sv
// Walks a memory descriptor forward, reverse or looping, streaming {lhs,rhs} character pairs.
module xform_streamer
    import xform_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned CHAR_W  = DEF_CHAR_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [1:0]              mode,
    input  logic [LEN_W+ADDR_W-1:0] desc,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [2*CHAR_W-1:0]     mem_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHAR_W-1:0]       out_lhs,
    output logic [CHAR_W-1:0]       out_rhs,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_W-1:0]        remaining,
    output logic [2:0]              state
);

    state_t             st, st_nxt;
    mode_t              mode_q;
    logic [ADDR_W-1:0]  addr, start_q;
    logic [LEN_W-1:0]   rem, len_q;
    logic [LEN_W-1:0]   d_len;
    logic [ADDR_W-1:0]  d_addr;
    logic               cap_v, accept, last_acc, loop_wrap, aborting;

    assign d_len  = desc[LEN_W+ADDR_W-1:ADDR_W];
    assign d_addr = desc[ADDR_W-1:0];

    assign aborting  = abort && (st != ST_IDLE);
    assign accept    = (st == ST_HOLD) && out_ready && !abort;
    assign last_acc  = accept && (rem == LEN_W'(1));
    assign loop_wrap = last_acc && (mode_q == MODE_LOOP);

    xform_lat_pipe #(
        .LAT(MEM_LAT)
    ) u_lat_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (abort),
        .in_valid (mem_en),
        .out_valid(cap_v)
    );

    always_ff @(posedge clk) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:  if (start) st_nxt = (d_len == '0) ? ST_FIN : ST_ISSUE;
            ST_ISSUE: st_nxt = ST_WAIT;
            ST_WAIT:  if (cap_v) st_nxt = ST_HOLD;
            ST_HOLD: begin
                if (accept) begin
                    if (last_acc && !loop_wrap) st_nxt = ST_FIN;
                    else                        st_nxt = ST_ISSUE;
                end
            end
            ST_FIN:   st_nxt = ST_IDLE;
            default:  st_nxt = ST_IDLE;
        endcase
        if (aborting) st_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_FWD;
            addr    <= '1;
            start_q <= '0;
            rem     <= '0;
            len_q   <= '0;
            out_lhs <= '0;
            out_rhs <= '0;
            done    <= 1'b0;
        end else begin
            done <= ((st == ST_FIN) && !abort) || loop_wrap;
            if (aborting) begin
                rem <= '0;
            end else if ((st == ST_IDLE) && start) begin
                len_q   <= d_len;
                start_q <= d_addr;
                rem     <= d_len;
                case (mode)
                    2'd1: begin
                        mode_q <= MODE_REV;
                        addr   <= d_addr + ADDR_W'(d_len) - ADDR_W'(1);
                    end
                    2'd2: begin
                        mode_q <= MODE_LOOP;
                        addr   <= d_addr;
                    end
                    default: begin
                        mode_q <= MODE_FWD;
                        addr   <= d_addr;
                    end
                endcase
            end else if ((st == ST_WAIT) && cap_v) begin
                out_lhs <= mem_dout[2*CHAR_W-1:CHAR_W];
                out_rhs <= mem_dout[CHAR_W-1:0];
            end else if (accept) begin
                if (loop_wrap) begin
                    rem  <= len_q;
                    addr <= start_q;
                end else begin
                    rem  <= rem - LEN_W'(1);
                    addr <= (mode_q == MODE_REV) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
                end
            end
        end
    end

    assign mem_en    = (st == ST_ISSUE);
    assign mem_addr  = addr;
    assign out_valid = (st == ST_HOLD);
    assign out_last  = (st == ST_HOLD) && (rem == LEN_W'(1));
    assign busy      = (st != ST_IDLE);
    assign remaining = rem;
    assign state     = st;

endmodule

// File: tb/tb_xform_streamer.sv
// Directed bench for xform_streamer: a MEM_LAT=1 instance and a MEM_LAT=3 instance for loop timing.
module tb_xform_streamer;

    localparam int AW = 10;
    localparam int LW = 10;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic [1:0]       mode = 2'd0;
    logic [LW+AW-1:0] desc = '0;
    logic             mem_en, out_valid, out_last, busy, done;
    logic [AW-1:0]    mem_addr;
    logic [2*CW-1:0]  mem_dout = '0;
    logic [CW-1:0]    out_lhs, out_rhs;
    logic [LW-1:0]    remaining;
    logic [2:0]       state;

    logic             start3 = 1'b0, abort3 = 1'b0, out_ready3 = 1'b1;
    logic [1:0]       mode3 = 2'd0;
    logic [LW+AW-1:0] desc3 = '0;
    logic             mem_en3, out_valid3, out_last3, busy3, done3;
    logic [AW-1:0]    mem_addr3;
    logic [2*CW-1:0]  mem_dout3 = '0, m3_d1 = '0, m3_d2 = '0;
    logic [CW-1:0]    out_lhs3, out_rhs3;
    logic [LW-1:0]    remaining3;
    logic [2:0]       state3;

    xform_streamer #(.ADDR_W(AW), .LEN_W(LW), .CHAR_W(CW), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .desc(desc),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_lhs(out_lhs), .out_rhs(out_rhs),
        .out_last(out_last), .busy(busy), .done(done), .remaining(remaining), .state(state)
    );

    xform_streamer #(.ADDR_W(AW), .LEN_W(LW), .CHAR_W(CW), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .mode(mode3), .desc(desc3),
        .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_dout(mem_dout3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_lhs(out_lhs3), .out_rhs(out_rhs3),
        .out_last(out_last3), .busy(busy3), .done(done3), .remaining(remaining3), .state(state3)
    );

    function automatic logic [2*CW-1:0] word_at(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'h5A, a[7:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_dout <= word_at(mem_addr);
        if (mem_en3) m3_d1 <= word_at(mem_addr3);
        m3_d2     <= m3_d1;
        mem_dout3 <= m3_d2;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] addr_q[$], lhs_q[$], rhs_q[$], last_q[$], rem_q[$], acc_t[$];
    logic [31:0] addr3_q[$], lhs3_q[$], last3_q[$], acc3_t[$];
    int done_cnt = 0, done_t = 0, valid_cnt = 0, done3_cnt = 0;

    always @(negedge clk) begin
        if (mem_en) addr_q.push_back(32'(mem_addr));
        if (out_valid) valid_cnt++;
        if (out_valid && out_ready && !abort) begin
            lhs_q.push_back(32'(out_lhs));
            rhs_q.push_back(32'(out_rhs));
            last_q.push_back(32'(out_last));
            rem_q.push_back(32'(remaining));
            acc_t.push_back(32'(cyc));
        end
        if (done) begin
            done_cnt++;
            done_t = cyc;
        end
        if (mem_en3) addr3_q.push_back(32'(mem_addr3));
        if (out_valid3 && out_ready3 && !abort3) begin
            lhs3_q.push_back(32'(out_lhs3));
            last3_q.push_back(32'(out_last3));
            acc3_t.push_back(32'(cyc));
        end
        if (done3) done3_cnt++;
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        addr_q.delete(); lhs_q.delete(); rhs_q.delete(); last_q.delete();
        rem_q.delete(); acc_t.delete();
        done_cnt = 0; valid_cnt = 0; done_t = 0;
    endtask

    int t_start;

    task automatic start_walk(input logic [1:0] m, input int len, input int sa);
        @(posedge clk); #1;
        mode    = m;
        desc    = {LW'(len), AW'(sa)};
        start   = 1'b1;
        t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end
        if (n >= budget) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (n >= budget) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        logic [31:0] s_lhs, s_rhs, s_last, s_rem;
        int n_addr, unstable, hc, n;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h3FF);
        check("rst_outs", {29'd0, out_valid, out_last, busy}, 32'd0);
        check("rst_data", {16'd0, out_lhs, out_rhs}, 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // forward walk
        clear_logs();
        start_walk(2'd0, 3, 'h010);
        run_until_idle("fwd", 60);
        check("fwd_n_addr", 32'(addr_q.size()), 32'd3);
        check("fwd_addr0", addr_q.size() > 0 ? addr_q[0] : 32'hX, 32'h010);
        check("fwd_addr1", addr_q.size() > 1 ? addr_q[1] : 32'hX, 32'h011);
        check("fwd_addr2", addr_q.size() > 2 ? addr_q[2] : 32'hX, 32'h012);
        check("fwd_n_pairs", 32'(lhs_q.size()), 32'd3);
        if (lhs_q.size() == 3) begin
            check("fwd_lhs0", lhs_q[0], 32'h4A);
            check("fwd_rhs0", rhs_q[0], 32'h10);
            check("fwd_lhs2", lhs_q[2], 32'h48);
            check("fwd_rhs2", rhs_q[2], 32'h12);
            check("fwd_last", {last_q[0][7:0], last_q[1][7:0], last_q[2][7:0]}, 32'h000001);
            check("fwd_rem", {rem_q[0][7:0], rem_q[1][7:0], rem_q[2][7:0]}, 32'h030201);
            check("fwd_spacing", acc_t[1] - acc_t[0], 32'd3);
        end
        check("fwd_done_cnt", 32'(done_cnt), 32'd1);

        // reverse with address wrap
        clear_logs();
        start_walk(2'd1, 3, 'h3FE);
        run_until_idle("rev", 60);
        check("rev_n_addr", 32'(addr_q.size()), 32'd3);
        check("rev_addr0", addr_q.size() > 0 ? addr_q[0] : 32'hX, 32'h000);
        check("rev_addr1", addr_q.size() > 1 ? addr_q[1] : 32'hX, 32'h3FF);
        check("rev_addr2", addr_q.size() > 2 ? addr_q[2] : 32'hX, 32'h3FE);
        check("rev_rhs1", rhs_q.size() > 1 ? rhs_q[1] : 32'hX, 32'hFF);
        check("rev_last2", last_q.size() > 2 ? last_q[2] : 32'hX, 32'd1);
        check("rev_done_cnt", 32'(done_cnt), 32'd1);

        // backpressure
        clear_logs();
        @(posedge clk); #1;
        out_ready = 1'b0;
        start_walk(2'd0, 2, 'h040);
        wait_valid("bp", 30);
        s_lhs = 32'(out_lhs); s_rhs = 32'(out_rhs); s_last = 32'(out_last); s_rem = 32'(remaining);
        n_addr = addr_q.size();
        unstable = 0;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || 32'(out_lhs) != s_lhs || 32'(out_rhs) != s_rhs ||
                32'(out_last) != s_last || 32'(remaining) != s_rem) unstable++;
        end
        check("bp_held_lhs", s_lhs, 32'h1A);
        check("bp_stable", 32'(unstable), 32'd0);
        check("bp_no_mem_en", 32'(addr_q.size()), 32'(n_addr));
        check("bp_remaining", s_rem, 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        run_until_idle("bp", 60);
        check("bp_n_pairs", 32'(lhs_q.size()), 32'd2);
        check("bp_done_cnt", 32'(done_cnt), 32'd1);

        // zero length
        clear_logs();
        start_walk(2'd0, 0, 'h020);
        run_until_idle("zero", 20);
        repeat (2) @(negedge clk);
        check("zero_mem_en", 32'(addr_q.size()), 32'd0);
        check("zero_valid", 32'(valid_cnt), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd1);
        check("zero_done_delay", 32'(done_t - t_start), 32'd2);

        // abort during second HOLD, then a fresh walk
        clear_logs();
        start_walk(2'd0, 4, 'h100);
        hc = 0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                hc++;
                if (hc == 2) begin
                    abort = 1'b1;
                    break;
                end
            end
        end
        check("abort_reached", 32'(hc), 32'd2);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_outs", {29'd0, out_valid, mem_en, busy}, 32'd0);
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_n_pairs", 32'(lhs_q.size()), 32'd1);
        clear_logs();
        start_walk(2'd0, 1, 'h200);
        run_until_idle("restart", 30);
        check("restart_addr", addr_q.size() > 0 ? addr_q[0] : 32'hX, 32'h200);
        check("restart_lhs", lhs_q.size() > 0 ? lhs_q[0] : 32'hX, 32'h5A);
        check("restart_done", 32'(done_cnt), 32'd1);

        // reset mid-walk discards the walk
        clear_logs();
        start_walk(2'd0, 4, 'h300);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_valid", 32'(valid_cnt), 32'd0);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'h3FF);
        check("midrst_done", 32'(done_cnt), 32'd0);

        // loop mode on the MEM_LAT=3 instance
        @(posedge clk); #1;
        mode3  = 2'd2;
        desc3  = {LW'(2), AW'('h010)};
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (acc3_t.size() >= 4) break;
        end
        if (n >= 100) check("loop_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
        check("loop_done_cnt", 32'(done3_cnt), 32'd2);
        @(posedge clk); #1;
        abort3 = 1'b1;
        @(posedge clk); #1;
        abort3 = 1'b0;
        check("loop_abort_idle", 32'(state3), 32'd0);
        if (addr3_q.size() >= 4 && acc3_t.size() >= 4) begin
            check("loop_addrs", {addr3_q[0][7:0], addr3_q[1][7:0], addr3_q[2][7:0], addr3_q[3][7:0]},
                  32'h10111011);
            check("loop_last", {last3_q[0][7:0], last3_q[1][7:0], last3_q[2][7:0], last3_q[3][7:0]},
                  32'h00010001);
            check("loop_lhs0", lhs3_q[0], 32'h4A);
            check("loop_lhs3", lhs3_q[3], 32'h4B);
            check("loop_spacing1", acc3_t[1] - acc3_t[0], 32'd5);
            check("loop_spacing2", acc3_t[2] - acc3_t[1], 32'd5);
        end else begin
            check("loop_n_pairs", 32'(acc3_t.size()), 32'd4);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/xform_streamer.md
XFORM_STREAMER -- requirements
Module: xform_streamer

Interface
REQ-001 Parameter ADDR_W, default 10, width of the memory address and of the descriptor start field.
REQ-002 Parameter LEN_W, default 10, width of the descriptor length field and of the remaining counter.
REQ-003 Parameter CHAR_W, default 8, width of each character; memory word = 2*CHAR_W, with lhs in the upper half and rhs in the lower half.
REQ-004 Parameter MEM_LAT, default 1, legal 1..3, read latency in cycles from mem_addr/mem_en to valid mem_dout.
REQ-005 Ports SHALL be:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle request to begin a walk
abort  in  1  cancel the walk in progress
mode  in  2  0=forward, 1=reverse, 2=loop-forward, 3=reserved (treated as 0)
desc  in  LEN_W+ADDR_W  {len, start_addr}
mem_en  out  1  read strobe
mem_addr  out  ADDR_W  read address
mem_dout  in  2*CHAR_W  read data
out_valid  out  1  character pair valid
out_ready  in  1  consumer accepts the pair
out_lhs  out  CHAR_W  original character
out_rhs  out  CHAR_W  transformed character
out_last  out  1  final pair of the pass
busy  out  1  walk in progress
done  out  1  one-cycle completion pulse
remaining  out  LEN_W  pairs not yet accepted in the current pass
state  out  3  FSM state encoding, for debug

Function
REQ-006 The FSM SHALL have states IDLE=0, ISSUE=1, WAIT=2, HOLD=3, FIN=4.
REQ-007 In IDLE, start=1 SHALL latch desc and mode, load remaining=len, and set base = start_addr (forward/loop) or start_addr+len-1 mod 2^ADDR_W (reverse); next state is ISSUE, or FIN if len=0.
REQ-008 start asserted outside IDLE SHALL be ignored.
REQ-009 ISSUE SHALL assert mem_en for exactly one cycle with mem_addr = current address, then enter WAIT.
REQ-010 WAIT SHALL last MEM_LAT cycles; on its final cycle the module SHALL capture mem_dout into the output register and enter HOLD.
REQ-011 In HOLD, out_valid=1; out_lhs, out_rhs and out_last SHALL remain stable until out_valid && out_ready.
REQ-012 out_last SHALL be 1 exactly when remaining=1 in HOLD.
REQ-013 On acceptance, remaining SHALL decrement and the address SHALL step +1 (forward/loop) or -1 (reverse), modulo 2^ADDR_W.
REQ-014 After accepting the last pair: forward/reverse SHALL go to FIN; loop SHALL reload remaining=len and address=start_addr, pulse done, and continue in ISSUE.
REQ-015 FIN SHALL assert done for one cycle and return to IDLE.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with out_valid=0 and mem_en=0; done SHALL NOT pulse. Abort takes priority over acceptance in the same cycle.
REQ-017 busy SHALL be 1 in every state other than IDLE.
REQ-018 Minimum throughput is one pair per MEM_LAT+2 cycles with out_ready held high.

Reset
REQ-019 On rst: state=IDLE, mem_en=0, mem_addr all-ones, out_valid=0, out_lhs=0, out_rhs=0, out_last=0, remaining=0, done=0, busy=0.
REQ-020 rst asserted mid-walk SHALL discard all latched descriptor state; any memory data returned afterward SHALL be ignored.

Structure
REQ-021 A shared package SHALL hold the state encoding constants, the mode encoding constants, and the default ADDR_W/LEN_W/CHAR_W values.
REQ-022 A sub-module xform_lat_pipe (a MEM_LAT-deep valid shift register) SHALL time the data capture.

Verification
REQ-023 Forward walk: desc={3,0x010}, mode=0, MEM_LAT=1, out_ready=1 -> addresses 0x010, 0x011, 0x012; three pairs; out_last on the third; one done pulse.
REQ-024 Reverse with wrap: desc={3,0x3FE}, mode=1 -> addresses 0x000, 0x3FF, 0x3FE.
REQ-025 Backpressure: out_ready=0 for 5 cycles in HOLD -> outputs stable, no new mem_en, remaining unchanged.
REQ-026 Zero length: desc={0,0x020}, start -> no mem_en, no out_valid, done pulses 2 cycles after start.
REQ-027 Abort: abort during the second HOLD of len=4 -> IDLE next cycle, out_valid=0, no done; a fresh start then succeeds.
REQ-028 Loop mode, len=2, MEM_LAT=3 -> address sequence 0x010, 0x011, 0x010, 0x011, with done at each wrap; pair spacing is 5 cycles.
